// File: rtl/vram_pkg.sv
// vram_pkg
// Shared constants and types for the screen-RAM arbiter.
//   VRAM_ADDR_WIDTH : default word address width (8192 words, 512x256 bitmap)
//   VRAM_DATA_WIDTH : default word width
//   VRAM_FIFO_DEPTH : default number of CPU write-FIFO entries
//   vram_state_t    : CPU read-path FSM states
//   vram_wentry_t   : one queued CPU write {addr, data} at the default widths
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH = 13;
  localparam int VRAM_DATA_WIDTH = 16;
  localparam int VRAM_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RD_WAIT   = 2'd1,
    ST_RD_ISSUED = 2'd2
  } vram_state_t;

  typedef struct packed {
    logic [VRAM_ADDR_WIDTH-1:0] addr;
    logic [VRAM_DATA_WIDTH-1:0] data;
  } vram_wentry_t;

endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo
// Small synchronous FIFO holding CPU writes until the screen RAM is free.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : enqueue one entry (ignored when full)
//   pop             : dequeue the head entry (ignored when empty)
//   head            : current head entry, valid while !empty
//   full, empty     : registered occupancy flags
// Push and pop in the same cycle are both honoured when the FIFO is not full.
module vram_wfifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port screen RAM between CPU screen accesses and the VGA
// scan-out reader. VGA reads always own the RAM; CPU writes are queued in a
// small FIFO and drained in free cycles; CPU reads wait for the FIFO to drain
// and a free cycle, so a read never overtakes an earlier write.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_addr, cpu_wdata             : CPU word address / write data
//   cpu_wren, cpu_rden              : CPU requests, accepted when cpu_ready=1
//   cpu_ready                       : request accepted this cycle
//   cpu_rdata, cpu_rvalid           : registered read data + one-cycle strobe
//   vga_raddr, vga_rden             : VGA read address / level request
//   vga_rdata                       : registered VGA data, holds last value
//   ram_addr, ram_wdata, ram_wren   : SPRAM command (combinational)
//   ram_rdata                       : SPRAM data, one cycle after a read
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_wren,
  input  logic                  cpu_rden,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic [ADDR_WIDTH-1:0] vga_raddr,
  input  logic                  vga_rden,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  vram_state_t           state;
  vram_state_t           state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  vga_owned;
  logic                  vga_owned_q;
  logic                  issue_rd;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  entry_t                fifo_head;
  entry_t                fifo_in;

  assign fifo_in = '{addr: cpu_addr, data: cpu_wdata};

  vram_wfifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RAM owner for this cycle: VGA, then queued write, then pending CPU read.
  // When nobody owns the RAM the address is parked on its previous value.
  always_comb begin
    ram_wren  = 1'b0;
    ram_addr  = last_addr;
    ram_wdata = fifo_head.data;
    fifo_pop  = 1'b0;
    issue_rd  = 1'b0;
    vga_owned = 1'b0;
    if (reset) begin
      ram_addr = '0;
    end else if (vga_rden) begin
      vga_owned = 1'b1;
      ram_addr  = vga_raddr;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      ram_wren = 1'b1;
      ram_addr = fifo_head.addr;
    end else if (state == ST_RD_WAIT) begin
      issue_rd = 1'b1;
      ram_addr = rd_addr;
    end
  end

  // CPU request FSM. Ready depends on the registered full flag, so a pop in
  // the same cycle cannot make room for a push. A write wins over a read
  // presented in the same cycle.
  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_ready = !fifo_full;
        if (cpu_wren && cpu_ready) begin
          fifo_push = 1'b1;
        end else if (cpu_rden && cpu_ready) begin
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (issue_rd) state_next = ST_RD_ISSUED;
      end
      ST_RD_ISSUED: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      last_addr   <= '0;
      vga_owned_q <= 1'b0;
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
      vga_rdata   <= '0;
    end else begin
      state       <= state_next;
      last_addr   <= ram_addr;
      vga_owned_q <= vga_owned;
      cpu_rvalid  <= (state == ST_RD_ISSUED);
      if (state == ST_IDLE && cpu_ready && cpu_rden && !cpu_wren) begin
        rd_addr <= cpu_addr;
      end
      // RAM data arrives one cycle after the owning cycle.
      if (state == ST_RD_ISSUED) cpu_rdata <= ram_rdata;
      if (vga_owned_q)           vga_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Self-checking bench for vram_arbiter with a behavioural SPRAM model.
// Expected RAM writes and CPU read results are queued when a request is
// accepted and compared by a monitor when the DUT produces them.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW = VRAM_ADDR_WIDTH;
  localparam int DW = VRAM_DATA_WIDTH;

  logic          clk;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wren;
  logic          cpu_rden;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] vga_raddr;
  logic          vga_rden;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem    [1 << AW];
  logic [DW-1:0] shadow [1 << AW];
  vram_wentry_t  wq [$];
  logic [DW-1:0] rq [$];

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wren   (cpu_wren),
    .cpu_rden   (cpu_rden),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .vga_raddr  (vga_raddr),
    .vga_rden   (vga_rden),
    .vga_rdata  (vga_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] = ram_wdata;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    vram_wentry_t e;
    logic [DW-1:0] d;
    if (!reset && ram_wren) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("[TB] FAIL ram_write_unexpected addr=%h data=%h required=no write", ram_addr, ram_wdata);
      end else begin
        e = wq.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          errors++;
          $display("[TB] FAIL ram_write_order got addr=%h data=%h required addr=%h data=%h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
    end
    if (!reset && cpu_rvalid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("[TB] FAIL cpu_rvalid_unexpected data=%h required=no read", cpu_rdata);
      end else begin
        d = rq.pop_front();
        if (cpu_rdata !== d) begin
          errors++;
          $display("[TB] FAIL cpu_rdata got=%h required=%h", cpu_rdata, d);
        end
      end
    end
  end

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    vram_wentry_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
    shadow[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_wren = 1'b0; cpu_rden = 1'b0;
    vga_raddr = '0; vga_rden = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b required=1", cpu_ready); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got=%b required=0", cpu_rvalid); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren got=%b required=0", ram_wren); end
    checks++; if (ram_addr !== '0) begin errors++; $display("[TB] FAIL reset_ram_addr got=%h required=0", ram_addr); end
    checks++; if (cpu_rdata !== '0) begin errors++; $display("[TB] FAIL reset_cpu_rdata got=%h required=0", cpu_rdata); end
    checks++; if (vga_rdata !== '0) begin errors++; $display("[TB] FAIL reset_vga_rdata got=%h required=0", vga_rdata); end
  endtask

  task automatic test_write_latency();
    @(posedge clk); #1;
    cpu_addr = 13'h0000; cpu_wdata = 16'h1234; cpu_wren = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_accept ready got=%b required=1", cpu_ready); end
    else push_write(13'h0000, 16'h1234);
    @(posedge clk); #1;
    cpu_wren = 1'b0;
    @(negedge clk);
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("[TB] FAIL wr_latency wren got=%b required=1", ram_wren); end
    checks++; if (ram_addr !== 13'h0000) begin errors++; $display("[TB] FAIL wr_latency addr got=%h required=0000", ram_addr); end
    checks++; if (ram_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL wr_latency data got=%h required=1234", ram_wdata); end
  endtask

  task automatic test_read_latency();
    repeat (2) @(posedge clk);
    #1;
    cpu_addr = 13'h0000; cpu_rden = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_accept ready got=%b required=1", cpu_ready); end
    else rq.push_back(shadow[0]);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      cpu_rden = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL rd_latency cycle N+%0d rvalid got=%b required=%b", k, cpu_rvalid, (k == 3));
      end
    end
  endtask

  task automatic test_fifo_full();
    int  idx;
    logic exp_ready;
    logic exp_wren;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      vga_rden  = (c < 8);
      vga_raddr = 13'h0020;
      cpu_wren  = (idx < 5);
      cpu_addr  = 13'(13'h0040 + idx);
      cpu_wdata = 16'(16'h1000 + idx);
      @(negedge clk);
      exp_ready = (c < 4) || (c == 9);
      exp_wren  = (c >= 8) && (c <= 12);
      if (cpu_wren) begin
        checks++;
        if (cpu_ready !== exp_ready) begin
          errors++;
          $display("[TB] FAIL fifo_ready cycle %0d got=%b required=%b", c, cpu_ready, exp_ready);
        end
      end
      checks++;
      if (ram_wren !== exp_wren) begin
        errors++;
        $display("[TB] FAIL fifo_drain cycle %0d wren got=%b required=%b", c, ram_wren, exp_wren);
      end
      if (cpu_wren && cpu_ready) begin
        push_write(cpu_addr, cpu_wdata);
        idx++;
      end
    end
    @(posedge clk); #1;
    cpu_wren = 1'b0; vga_rden = 1'b0;
  endtask

  task automatic test_raw();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    vga_rden = 1'b0; vga_raddr = 13'h0020;
    cpu_addr = 13'h1FFF; cpu_wdata = 16'hBEEF; cpu_wren = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_wr_accept got=%b required=1", cpu_ready); end
    else push_write(13'h1FFF, 16'hBEEF);
    @(posedge clk); #1;
    cpu_wren = 1'b0; cpu_rden = 1'b1; vga_rden = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_rd_accept got=%b required=1", cpu_ready); end
    else rq.push_back(shadow[13'h1FFF]);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cpu_rden = 1'b0;
      vga_rden = (c % 2 == 0);
      @(negedge clk);
      if (cpu_rvalid === 1'b1) begin
        pulses++;
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL raw_data got=%h required=BEEF", cpu_rdata); end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL raw_pulses got=%0d required=1", pulses); end
    @(posedge clk); #1;
    vga_rden = 1'b0;
  endtask

  task automatic test_vga();
    logic [DW-1:0] exp;
    @(posedge clk); #1;
    vga_rden = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      vga_raddr = 13'h0100;
      vga_rden  = (k < 4);
      @(negedge clk);
      exp = (k < 2) ? 16'h0000 : shadow[13'h0100];
      checks++;
      if (vga_rdata !== exp) begin
        errors++;
        $display("[TB] FAIL vga_rdata T+%0d got=%h required=%h", k, vga_rdata, exp);
      end
    end
  endtask

  task automatic test_wr_rd_together();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    cpu_addr = 13'h0300; cpu_wdata = 16'h5A5A; cpu_wren = 1'b1; cpu_rden = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL both_accept got=%b required=1", cpu_ready); end
    else push_write(13'h0300, 16'h5A5A);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      cpu_wren = 1'b0; cpu_rden = 1'b0;
      @(negedge clk);
      if (cpu_rvalid === 1'b1) pulses++;
      if (c == 0) begin
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL both_still_idle ready got=%b required=1", cpu_ready); end
      end
    end
    checks++;
    if (pulses != 0) begin errors++; $display("[TB] FAIL both_rvalid pulses got=%0d required=0", pulses); end
    checks++;
    if (wq.size() != 0) begin errors++; $display("[TB] FAIL both_write_pending got=%0d required=0", wq.size()); end
  endtask

  task automatic test_reset_in_rd_wait();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vga_rden = 1'b1; vga_raddr = 13'h0020;
      cpu_addr = 13'(13'h0500 + i); cpu_wdata = 16'(16'h7700 + i); cpu_wren = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_q_accept %0d got=%b required=1", i, cpu_ready); end
      else push_write(cpu_addr, cpu_wdata);
    end
    @(posedge clk); #1;
    cpu_wren = 1'b0; cpu_rden = 1'b1; cpu_addr = 13'h0500;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_accept got=%b required=1", cpu_ready); end
    @(posedge clk); #1;
    cpu_rden = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_wait ready got=%b required=0", cpu_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    wq.delete();
    rq.delete();
    @(posedge clk); #1;
    reset = 1'b0; vga_rden = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_after ready got=%b required=1", cpu_ready); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_after rvalid got=%b required=0", cpu_rvalid); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_after wren got=%b required=0", ram_wren); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ram_wren !== 1'b0 || cpu_rvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL rst_quiet activity cycles got=%0d required=0", bad); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    mem[13'h0100]    = 16'hA5A5;
    shadow[13'h0100] = 16'hA5A5;
    test_reset();
    test_write_latency();
    test_read_latency();
    test_fifo_full();
    test_raw();
    test_vga();
    test_wr_rd_together();
    test_reset_in_rd_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
